// File: rtl/ccsds123_axis_out.sv
// Output stage for ccsds123_top: buffers the unthrottled res word stream in a
// first-word-fall-through FIFO and re-emits it as an AXI4-Stream master.
module ccsds123_axis_out #(
    parameter int BUS_WIDTH          = 32,
    parameter int DEPTH              = 16,
    parameter int ALMOST_FULL_MARGIN = 4
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic [BUS_WIDTH-1:0]       res,
    input  logic                       res_valid,
    input  logic                       res_last,
    output logic [BUS_WIDTH-1:0]       m_axis_tdata,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic                       almost_full,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int LVL_W     = $clog2(DEPTH) + 1;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int RAM_DEPTH = DEPTH - 1;
    localparam int WORD_W    = BUS_WIDTH + 1;

    logic [WORD_W-1:0]    ram_r [0:RAM_DEPTH-1];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [LVL_W-1:0]     level_r;
    logic [BUS_WIDTH-1:0] tdata_r;
    logic                 tlast_r;
    logic                 tvalid_r;
    logic                 almost_full_r;
    logic                 overflow_r;

    logic                 pop_s;
    logic                 full_s;
    logic                 wr_en_s;
    logic                 drop_s;
    logic                 ram_empty_s;
    logic                 load_out_s;
    logic                 rd_en_s;
    logic                 bypass_s;
    logic                 ram_wr_s;
    logic [LVL_W-1:0]     level_nxt_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(RAM_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Datapath steering: the output register is refilled from the RAM when it
    // holds words, otherwise directly from res so an empty FIFO costs one cycle.
    always_comb begin
        pop_s       = tvalid_r & m_axis_tready;
        full_s      = (level_r == LVL_W'(DEPTH));
        wr_en_s     = res_valid & (~full_s | pop_s);
        drop_s      = res_valid & full_s & ~pop_s;
        ram_empty_s = (level_r <= LVL_W'(1));
        load_out_s  = ~tvalid_r | pop_s;
        rd_en_s     = load_out_s & ~ram_empty_s;
        bypass_s    = load_out_s & ram_empty_s & wr_en_s;
        ram_wr_s    = wr_en_s & ~bypass_s;
        case ({wr_en_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // RAM array; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (ram_wr_s) begin
            ram_r[wr_ptr_r] <= {res_last, res};
        end
    end

    // Pointers, output register, level and status flags.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            level_r       <= '0;
            tdata_r       <= '0;
            tlast_r       <= 1'b0;
            tvalid_r      <= 1'b0;
            almost_full_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            if (ram_wr_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (rd_en_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
                {tlast_r, tdata_r} <= ram_r[rd_ptr_r];
                tvalid_r <= 1'b1;
            end else if (bypass_s) begin
                tdata_r  <= res;
                tlast_r  <= res_last;
                tvalid_r <= 1'b1;
            end else if (pop_s) begin
                tvalid_r <= 1'b0;
            end
            level_r       <= level_nxt_s;
            almost_full_r <= (level_nxt_s >= LVL_W'(DEPTH - ALMOST_FULL_MARGIN));
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign m_axis_tdata  = tdata_r;
    assign m_axis_tlast  = tlast_r;
    assign m_axis_tvalid = tvalid_r;
    assign almost_full   = almost_full_r;
    assign overflow      = overflow_r;
    assign level         = level_r;

endmodule

// File: tb/tb_ccsds123_axis_out.sv
// Randomised and directed bench for ccsds123_axis_out against a queue-based
// model of the FIFO's visible behaviour.
module tb_ccsds123_axis_out;

    localparam int BW    = 32;
    localparam int DEPTH = 16;
    localparam int AFM   = 4;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic [BW-1:0] res = '0;
    logic          res_valid = 1'b0;
    logic          res_last = 1'b0;
    logic [BW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b0;
    logic          almost_full;
    logic          overflow;
    logic [$clog2(DEPTH):0] level;

    ccsds123_axis_out #(.BUS_WIDTH(BW), .DEPTH(DEPTH), .ALMOST_FULL_MARGIN(AFM)) dut (
        .clk(clk), .areset(areset), .res(res), .res_valid(res_valid), .res_last(res_last),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready), .almost_full(almost_full), .overflow(overflow),
        .level(level)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue of {last, data}; everything held is visible.
    logic [BW:0] mq[$];
    bit          m_ovf = 1'b0;

    always @(posedge clk or posedge areset) begin
        if (areset) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            int  sz;
            bit  pop;
            sz  = mq.size();
            pop = (sz > 0) && m_axis_tready;
            if (pop) void'(mq.pop_front());
            if (res_valid) begin
                if (sz < DEPTH || pop) mq.push_back({res_last, res});
                else m_ovf = 1'b1;
            end
        end
    end

    // Compare process: outputs against the model every cycle, plus AXI stability.
    logic [BW-1:0] prev_data;
    logic          prev_last;
    bit            prev_stall = 1'b0;

    always @(negedge clk) begin
        int sz;
        sz = mq.size();
        chk("tvalid", m_axis_tvalid, sz != 0);
        chk("level", level, sz);
        chk("almost_full", almost_full, sz >= DEPTH - AFM);
        chk("overflow", overflow, m_ovf);
        if (sz != 0) begin
            chk("tdata", m_axis_tdata, mq[0][BW-1:0]);
            chk("tlast", m_axis_tlast, mq[0][BW]);
        end
        if (prev_stall && !areset) begin
            chk("stable_tdata", m_axis_tdata, prev_data);
            chk("stable_tlast", m_axis_tlast, prev_last);
        end
        prev_stall = m_axis_tvalid && !m_axis_tready && !areset;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
    end

    // One clock of stimulus: inputs are applied 2 time units after an edge.
    task automatic cyc(input bit v, input logic [BW-1:0] d, input bit l, input bit r);
        res_valid     = v;
        res           = d;
        res_last      = l;
        m_axis_tready = r;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        #1;
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 1'b0);
        @(posedge clk);
        #1;
        areset = 1'b0;
        #1;
    endtask

    initial begin
        int nlast;
        logic [BW-1:0] lastdata;
        int w;
        int cnt;
        #17;
        areset = 1'b0;
        chk("reset_level", level, 0);
        chk("reset_tdata", m_axis_tdata, 0);

        // 1: single word, one-cycle latency
        cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
        chk("t1_tvalid", m_axis_tvalid, 1'b1);
        chk("t1_tdata", m_axis_tdata, 32'hDEADBEEF);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t1_level", level, 0);

        // 2: fill to full, almost_full at 12, then drain in order
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, i, 1'b0, 1'b0);
            if (i == 10) chk("t2_af_below", almost_full, 1'b0);
            if (i == 11) chk("t2_af_at12", almost_full, 1'b1);
        end
        chk("t2_level", level, 16);
        chk("t2_ovf", overflow, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("t2_drain", m_axis_tdata, i);
            cyc(1'b0, 32'h0, 1'b0, 1'b1);
        end
        chk("t2_empty", level, 0);

        // 3: overflow drops the word and is sticky
        for (int i = 0; i < 16; i++) cyc(1'b1, i, 1'b0, 1'b0);
        cyc(1'b1, 32'h99, 1'b0, 1'b0);
        chk("t3_ovf", overflow, 1'b1);
        chk("t3_level", level, 16);
        for (int i = 0; i < 16; i++) begin
            chk("t3_drain", m_axis_tdata, i);
            cyc(1'b0, 32'h0, 1'b0, 1'b1);
        end
        chk("t3_ovf_sticky", overflow, 1'b1);
        chk("t3_empty", m_axis_tvalid, 1'b0);

        // 4: full with simultaneous push/pop across pointer wrap
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1'b1, i, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            chk("t4_seq", m_axis_tdata, k);
            cyc(1'b1, 16 + k, 1'b0, 1'b1);
            chk("t4_level", level, 16);
        end
        chk("t4_ovf", overflow, 1'b0);
        for (int k = 0; k < 16; k++) cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // 5: 64-word image with random backpressure, upstream throttled by almost_full
        do_reset();
        nlast = 0;
        lastdata = '0;
        w = 0;
        cnt = 0;
        while (!(w == 64 && level == 0) && cnt < 2000) begin
            bit v;
            bit r;
            v = (w < 64) && !almost_full;
            r = 1'($urandom_range(0, 1));
            if (m_axis_tvalid && r && m_axis_tlast) begin
                nlast++;
                lastdata = m_axis_tdata;
            end
            cyc(v, w, v && (w == 63), r);
            if (v) w++;
            cnt++;
        end
        chk("t5_done", cnt < 2000, 1'b1);
        chk("t5_nlast", nlast, 1);
        chk("t5_lastword", lastdata, 63);
        chk("t5_ovf", overflow, 1'b0);

        // 6: reset mid-stream, then new words flow normally
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h100 + i, 1'b0, 1'b0);
        chk("t6_loaded", level, 5);
        do_reset();
        cyc(1'b1, 32'hA, 1'b0, 1'b0);
        cyc(1'b1, 32'hB, 1'b1, 1'b0);
        chk("t6_first", m_axis_tdata, 32'hA);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t6_second", m_axis_tdata, 32'hB);
        chk("t6_last", m_axis_tlast, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t6_empty", level, 0);
        chk("t6_ovf", overflow, 1'b0);

        // Random soak: varying input/output rates, occasional overflow
        for (int ph = 0; ph < 4; ph++) begin
            int pv;
            int pr;
            pv = 25 * (ph + 1);
            pr = 100 - 20 * ph;
            for (int c = 0; c < 500; c++) begin
                cyc($urandom_range(0, 99) < pv, $urandom, 1'($urandom_range(0, 7) == 0),
                    $urandom_range(0, 99) < pr);
            end
        end
        for (int c = 0; c < 20; c++) cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("soak_drained", level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
